// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MIPS datapath and the data-memory responder.
// The pipeline side is the master; the responder is the slave.
interface dmem_responder_if;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        done;
   logic        err;

   modport master (
      output MemRead, MemWrite, addr, wdata,
      input  rdata, stall, done, err
   );

   modport slave (
      input  MemRead, MemWrite, addr, wdata,
      output rdata, stall, done, err
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: captures an lw/sw request, stalls for WAIT cycles, then performs the
// access against an internal word array and pulses done (with err for misaligned/illegal ops).
module dmem_responder #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned WAIT  = 2
) (
   input logic              clk,
   input logic              rst,
   dmem_responder_if.slave  bus
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StWaiting, StResp} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic        rd_q, wr_q, err_q;

   logic        req, capture, access;
   logic [31:0] acc_addr, acc_wdata;
   logic        acc_rd, acc_wr, acc_err;
   logic [AW-1:0] idx;

   logic [31:0] mem [DEPTH];

   logic unused_addr;
   assign unused_addr = ^{bus.addr[31:AW+2], addr_q[31:AW+2]};

   assign req = bus.MemRead | bus.MemWrite;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      access  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               capture = 1'b1;
               if (WAIT == 0) begin
                  state_d = StResp;
                  access  = 1'b1;
               end else begin
                  state_d = StWaiting;
                  cnt_d   = 4'(WAIT - 1);
               end
            end
         end
         StWaiting: begin
            if (cnt_q == 4'd0) begin
               state_d = StResp;
               access  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // With WAIT==0 the access happens on the capture edge, so use the live request.
   always_comb begin
      if (state_q == StIdle) begin
         acc_addr  = bus.addr;
         acc_wdata = bus.wdata;
         acc_rd    = bus.MemRead;
         acc_wr    = bus.MemWrite;
      end else begin
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
         acc_rd    = rd_q;
         acc_wr    = wr_q;
      end
   end

   assign acc_err = (acc_addr[1:0] != 2'b00) | (acc_rd & acc_wr);
   assign idx     = acc_addr[AW+1:2];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (capture) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            rd_q    <= bus.MemRead;
            wr_q    <= bus.MemWrite;
         end
         if (access) begin
            err_q <= acc_err;
            if (acc_rd) begin
               rdata_q <= acc_err ? 32'd0 : mem[idx];
            end
         end
      end
   end

   // Array contents survive reset; only an in-flight write is cancelled by it.
   always_ff @(posedge clk) begin
      if (!rst && access && acc_wr && !acc_err) begin
         mem[idx] <= acc_wdata;
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.done  = !rst && (state_q == StResp);
   assign bus.err   = !rst && (state_q == StResp) && err_q;
   assign bus.stall = !rst && (((state_q == StIdle) && req) || (state_q == StWaiting));

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset/WAIT=0 sequences and randomized
// accesses checked against a word-array reference model.
module tb_dmem_responder;

   localparam int unsigned DEPTH = 256;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_responder_if bus2 ();
   dmem_responder_if bus0 ();

   dmem_responder #(.DEPTH(DEPTH), .WAIT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
   dmem_responder #(.DEPTH(DEPTH), .WAIT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

   int tests = 0;
   int fails = 0;

   // Reference model for the WAIT=2 instance
   logic [31:0] mdl_mem [int];
   logic [31:0] mdl_rdata;
   bit          mdl_known;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] a;
      logic [31:0] d;
      bit          xerr;
      logic [31:0] xrdata;
   } vec_t;

   vec_t vt [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic drive(input int sel, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
      if (sel == 2) begin
         bus2.MemRead = rd; bus2.MemWrite = wr; bus2.addr = a; bus2.wdata = d;
      end else begin
         bus0.MemRead = rd; bus0.MemWrite = wr; bus0.addr = a; bus0.wdata = d;
      end
   endtask

   task automatic sample(input int sel, output logic st, output logic dn, output logic er,
                         output logic [31:0] rdat);
      if (sel == 2) begin
         st = bus2.stall; dn = bus2.done; er = bus2.err; rdat = bus2.rdata;
      end else begin
         st = bus0.stall; dn = bus0.done; er = bus0.err; rdat = bus0.rdata;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
         drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      end
   endtask

   // One access starting at the next cycle; checks stall/done/err every cycle of its latency.
   // The request stays driven afterwards so a following call is back-to-back.
   task automatic do_acc(input int sel, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input bit drop,
                         output logic [31:0] rdat_o, output logic err_o);
      int w;
      logic st, dn, er;
      logic [31:0] rdat;
      w = (sel == 2) ? 2 : 0;
      rdat_o = 32'd0;
      err_o  = 1'b0;
      @(posedge clk); #1;
      drive(sel, rd, wr, a, d);
      for (int k = 0; k <= w + 1; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
            if (drop && k == 1) drive(sel, 1'b0, 1'b0, ~a, ~d);
         end
         @(negedge clk);
         sample(sel, st, dn, er, rdat);
         check($sformatf("w%0d stall c%0d", w, k), 32'(st), 32'(k <= w));
         check($sformatf("w%0d done c%0d", w, k), 32'(dn), 32'(k == w + 1));
         if (k == w + 1) begin
            rdat_o = rdat;
            err_o  = er;
         end else begin
            check($sformatf("w%0d err c%0d", w, k), 32'(er), 32'd0);
         end
      end
   endtask

   task automatic model_apply(input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] d, output bit xerr,
                              output logic [31:0] xrdata, output bit chk);
      int idx;
      bit mis;
      idx  = int'((a >> 2) % DEPTH);
      mis  = (a % 4) != 0;
      xerr = mis || (rd && wr);
      if (wr && !rd && !mis) mdl_mem[idx] = d;
      if (rd) begin
         if (xerr) begin
            mdl_rdata = 32'd0; mdl_known = 1'b1;
         end else if (mdl_mem.exists(idx)) begin
            mdl_rdata = mdl_mem[idx]; mdl_known = 1'b1;
         end else begin
            mdl_known = 1'b0;
         end
      end
      xrdata = mdl_rdata;
      chk    = mdl_known;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rdat;
      logic        er, st, dn;
      logic [31:0] xr;
      bit          xe, chk;

      vt[0]  = '{0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0000_0000};
      vt[1]  = '{1, 0, 32'h0000_0010, 32'h0000_0000, 0, 32'hDEAD_BEEF};
      vt[2]  = '{1, 0, 32'h0000_0013, 32'h0000_0000, 1, 32'h0000_0000};
      vt[3]  = '{1, 0, 32'h0000_0010, 32'h0000_0000, 0, 32'hDEAD_BEEF};
      vt[4]  = '{0, 1, 32'h0000_0020, 32'h1111_1111, 0, 32'hDEAD_BEEF};
      vt[5]  = '{1, 1, 32'h0000_0020, 32'h2222_2222, 1, 32'h0000_0000};
      vt[6]  = '{1, 0, 32'h0000_0020, 32'h0000_0000, 0, 32'h1111_1111};
      vt[7]  = '{0, 1, 32'h0000_0400, 32'hA5A5_A5A5, 0, 32'h1111_1111};
      vt[8]  = '{1, 0, 32'h0000_0000, 32'h0000_0000, 0, 32'hA5A5_A5A5};
      vt[9]  = '{0, 1, 32'h0000_0011, 32'h0000_0BAD, 1, 32'hA5A5_A5A5};
      vt[10] = '{1, 0, 32'h0000_0010, 32'h0000_0000, 0, 32'hDEAD_BEEF};
      vt[11] = '{0, 1, 32'h0000_0040, 32'hCAFE_F00D, 0, 32'hDEAD_BEEF};
      vt[12] = '{1, 0, 32'h0000_0040, 32'h0000_0000, 0, 32'hCAFE_F00D};
      vt[13] = '{1, 0, 32'hFFFF_F443, 32'h0000_0000, 1, 32'h0000_0000};

      // Reset with a request pending: stall must stay low while rst is high
      rst = 1'b1;
      drive(2, 1'b1, 1'b0, 32'h10, 32'd0);
      drive(0, 1'b0, 1'b1, 32'h10, 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      sample(2, st, dn, er, rdat);
      check("rst stall", 32'(st), 32'd0);
      check("rst done", 32'(dn), 32'd0);
      check("rst err", 32'(er), 32'd0);
      check("rst rdata", rdat, 32'd0);
      sample(0, st, dn, er, rdat);
      check("rst w0 stall", 32'(st), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      mdl_rdata = 32'd0;
      mdl_known = 1'b1;
      idle(2);

      foreach (vt[i]) begin
         do_acc(2, vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, 1'b0, rdat, er);
         check($sformatf("vec%0d err", i), 32'(er), 32'(vt[i].xerr));
         check($sformatf("vec%0d rdata", i), rdat, vt[i].xrdata);
         model_apply(vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, xe, xr, chk);
      end

      // Reset during WAITING of a store: access aborted, memory keeps old word
      @(posedge clk); #1;
      drive(2, 1'b0, 1'b1, 32'h40, 32'h1234_5678);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      sample(2, st, dn, er, rdat);
      check("abort stall", 32'(st), 32'd0);
      check("abort done", 32'(dn), 32'd0);
      check("abort rdata", rdat, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      mdl_rdata = 32'd0;
      mdl_known = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         sample(2, st, dn, er, rdat);
         check($sformatf("abort quiet done c%0d", c), 32'(dn), 32'd0);
         check($sformatf("abort quiet stall c%0d", c), 32'(st), 32'd0);
      end
      do_acc(2, 1'b1, 1'b0, 32'h40, 32'd0, 1'b0, rdat, er);
      check("abort readback", rdat, 32'hCAFE_F00D);
      model_apply(1'b1, 1'b0, 32'h40, 32'd0, xe, xr, chk);

      // WAIT=0 instance: store then immediate load, then illegal op
      idle(1);
      do_acc(0, 1'b0, 1'b1, 32'h0, 32'h1357_9BDF, 1'b0, rdat, er);
      check("w0 sw err", 32'(er), 32'd0);
      check("w0 sw rdata", rdat, 32'd0);
      do_acc(0, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, rdat, er);
      check("w0 lw rdata", rdat, 32'h1357_9BDF);
      check("w0 lw err", 32'(er), 32'd0);
      do_acc(0, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, 1'b0, rdat, er);
      check("w0 both err", 32'(er), 32'd1);
      check("w0 both rdata", rdat, 32'd0);
      do_acc(0, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, rdat, er);
      check("w0 after both", rdat, 32'h1357_9BDF);
      idle(1);

      // Randomized traffic on the WAIT=2 instance, including mid-wait request drops
      for (int n = 0; n < 300; n++) begin
         int unsigned op, widx;
         logic [31:0] a, d;
         bit rd, wr, drop;
         op   = $urandom_range(0, 9);
         widx = $urandom_range(0, 15);
         a    = ($urandom() & ~32'h0000_03FF) | (32'(widx) << 2);
         if (op == 9) a[1:0] = 2'($urandom_range(1, 3));
         d    = $urandom();
         rd   = (op >= 4 && op <= 8) || (op == 9 && d[0]);
         wr   = (op <= 3) || (op == 8) || (op == 9 && !d[0]);
         drop = ($urandom_range(0, 3) == 0);
         do_acc(2, rd, wr, a, d, drop, rdat, er);
         model_apply(rd, wr, a, d, xe, xr, chk);
         check($sformatf("rnd%0d err", n), 32'(er), 32'(xe));
         if (chk) check($sformatf("rnd%0d rdata", n), rdat, xr);
         if ($urandom_range(0, 4) == 0) idle(1);
      end
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
